// File: rtl/inst_assembler.sv
// RV32 field-to-word encoder that streams validated instruction words into
// instruction memory through a registered write port, one word per cycle.
module inst_assembler #(
  parameter  int ADDR_W    = 32,
  parameter  int MAX_WORDS = 1024,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CW-1:0]     word_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FULL, DRAIN} state_t;

  localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        enc;
  logic [1:0]         code;
  logic signed [31:0] simm;
  logic               acc;

  assign simm     = imm;
  assign in_ready = (state == RUN) && (word_count < MAXW) && !finish;
  assign acc      = in_valid && in_ready;

  // Range is checked before alignment so the first failing check wins.
  always_comb begin
    enc  = '0;
    code = 2'd0;
    case (fmt)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        enc = {imm[11:0], rs1, funct3, rd, opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) code = 2'd1;
      end
      3'd2: begin
        enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) code = 2'd1;
      end
      3'd3: begin
        enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (simm < -32'sd4096 || simm > 32'sd4094) code = 2'd1;
        else if (imm[0])                           code = 2'd2;
      end
      3'd4: begin
        enc = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) code = 2'd2;
      end
      3'd5: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (simm < -32'sd1048576 || simm > 32'sd1048574) code = 2'd1;
        else if (imm[0])                                 code = 2'd2;
      end
      default: code = 2'd3;
    endcase
  end

  // busy tracks RUN and DRAIN only; FULL drops it until finish arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          addr       <= {base_addr[ADDR_W-1:2], 2'b00};
          word_count <= '0;
          busy       <= 1'b1;
        end
        RUN: begin
          if (finish) begin
            state <= DRAIN;
          end else if (acc) begin
            if (code == 2'd0) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= enc;
              addr       <= addr + ADDR_W'(4);
              word_count <= word_count + 1'b1;
              if (word_count + 1'b1 == MAXW) begin
                state <= FULL;
                busy  <= 1'b0;
              end
            end else begin
              err      <= 1'b1;
              err_code <= code;
            end
          end
        end
        FULL: if (finish) begin
          state <= DRAIN;
          busy  <= 1'b1;
        end
        DRAIN: begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_assembler.sv
// Directed bench for inst_assembler: encodings, rejection codes, session
// control, full-session limit, async reset and address wrap.
module tb_inst_assembler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 0, finish = 0, in_valid = 0;
  logic        start2 = 0, finish2 = 0, in_valid2 = 0;
  logic [31:0] base_addr = '0;
  logic [2:0]  fmt = '0, funct3 = '0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, imem_we, err, busy, done;
  logic [31:0] imem_addr, imem_wdata;
  logic [1:0]  err_code;
  logic [10:0] word_count;
  logic        in_ready2, imem_we2, err2, busy2, done2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [1:0]  err_code2;
  logic [1:0]  word_count2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  inst_assembler #(.ADDR_W(32), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err(err), .err_code(err_code), .word_count(word_count), .busy(busy), .done(done));

  inst_assembler #(.ADDR_W(32), .MAX_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr), .finish(finish2),
    .in_valid(in_valid2), .in_ready(in_ready2), .fmt(fmt), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .err(err2), .err_code(err_code2), .word_count(word_count2), .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setb(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic expw(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_data"}, imem_wdata, d);
  endtask

  task automatic expe(input string tag, input logic [1:0] c);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, c});
    chk({tag, "_nowe"}, {31'd0, imem_we}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    tick(); tick();
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_we", {31'd0, imem_we}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_code", {30'd0, err_code}, 0);
    chk("rst_wc", {21'd0, word_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    tick();

    // Session at 0x100 with the five reference instructions back to back
    base_addr = 32'h100; start = 1; tick(); start = 0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_ready", {31'd0, in_ready}, 1);
    in_valid = 1;
    setb(1, 7'h13, 0, 0, 1, 0, 0, 5);                tick(); expw("addi", 32'h100, 32'h00500093);
    setb(2, 7'h23, 2, 0, 0, 1, 2, 8);                tick(); expw("sw",   32'h104, 32'h0020A423);
    setb(3, 7'h63, 0, 0, 0, 0, 0, -32'sd4);          tick(); expw("beq",  32'h108, 32'hFE000EE3);
    setb(5, 7'h6F, 0, 0, 1, 0, 0, 2048);             tick(); expw("jal",  32'h10C, 32'h001000EF);
    setb(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000);     tick(); expw("lui",  32'h110, 32'h123452B7);
    chk("wc5", {21'd0, word_count}, 5);

    // Rejections interleaved with good words
    setb(1, 7'h13, 0, 0, 1, 0, 0, 2048);             tick(); expe("i_range", 1);
    chk("wc_hold", {21'd0, word_count}, 5);
    setb(1, 7'h13, 0, 0, 2, 3, 0, 32'hFFFFFFFF);     tick(); expw("addi_m1", 32'h114, 32'hFFF18113);
    chk("err_clr", {31'd0, err}, 0);
    setb(3, 7'h63, 0, 0, 0, 0, 0, 6);                tick(); expw("b6", 32'h118, 32'h00000363);
    setb(3, 7'h63, 0, 0, 0, 0, 0, 7);                tick(); expe("b7", 2);
    setb(7, 7'h13, 0, 0, 0, 0, 0, 0);                tick(); expe("fmt7", 3);
    setb(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345001);     tick(); expe("u_low", 2);
    setb(3, 7'h63, 0, 0, 0, 0, 0, 4095);             tick(); expe("b_4095", 1);
    setb(5, 7'h6F, 0, 0, 1, 0, 0, 1048576);          tick(); expe("j_range", 1);
    in_valid = 0; tick();
    chk("idle_we", {31'd0, imem_we}, 0);
    chk("code_hold", {30'd0, err_code}, 1);
    chk("wc7", {21'd0, word_count}, 7);

    // finish together with a valid bundle: not accepted
    setb(1, 7'h13, 0, 0, 1, 0, 0, 1);
    in_valid = 1; finish = 1; #1;
    chk("fin_ready", {31'd0, in_ready}, 0);
    tick(); in_valid = 0; finish = 0;
    chk("fin_nowe", {31'd0, imem_we}, 0);
    chk("drain_busy", {31'd0, busy}, 1);
    chk("drain_done", {31'd0, done}, 0);
    tick();
    chk("done", {31'd0, done}, 1);
    chk("done_busy", {31'd0, busy}, 0);
    tick();
    chk("done_once", {31'd0, done}, 0);

    // Async reset during back-to-back writes
    base_addr = 32'h200; start = 1; tick(); start = 0;
    in_valid = 1;
    setb(1, 7'h13, 0, 0, 1, 0, 0, 1); tick(); expw("pre_rst0", 32'h200, 32'h00100093);
    setb(1, 7'h13, 0, 0, 1, 0, 0, 2); tick(); expw("pre_rst1", 32'h204, 32'h00200093);
    rst = 1; #1;
    chk("arst_we", {31'd0, imem_we}, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_wdata", imem_wdata, 0);
    chk("arst_wc", {21'd0, word_count}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_ready", {31'd0, in_ready}, 0);
    rst = 0; in_valid = 0;
    tick(); tick();
    chk("arst_nodone", {31'd0, done}, 0);
    base_addr = 32'h0; start = 1; tick(); start = 0;
    in_valid = 1;
    setb(1, 7'h13, 0, 0, 1, 0, 0, 3); tick(); expw("post_rst", 32'h0, 32'h00300093);
    chk("post_rst_wc", {21'd0, word_count}, 1);
    in_valid = 0; finish = 1; tick(); finish = 0; tick();
    chk("post_rst_done", {31'd0, done}, 1);

    // Address wrap
    base_addr = 32'hFFFFFFFC; start = 1; tick(); start = 0;
    in_valid = 1;
    setb(4, 7'h37, 0, 0, 1, 0, 0, 32'h00001000); tick(); expw("wrap0", 32'hFFFFFFFC, 32'h000010B7);
    setb(0, 7'h33, 0, 7'h20, 3, 1, 2, 0);        tick(); expw("wrap1", 32'h0, 32'h402081B3);
    in_valid = 0; finish = 1; tick(); finish = 0; tick();
    chk("wrap_done", {31'd0, done}, 1);

    // MAX_WORDS=2 instance: third bundle must stall
    base_addr = 32'h40; start2 = 1; tick(); start2 = 0;
    setb(1, 7'h13, 0, 0, 1, 0, 0, 9);
    in_valid2 = 1;
    chk("m2_ready", {31'd0, in_ready2}, 1);
    tick();
    chk("m2_we0", {31'd0, imem_we2}, 1);
    chk("m2_addr0", imem_addr2, 32'h40);
    tick();
    chk("m2_we1", {31'd0, imem_we2}, 1);
    chk("m2_addr1", imem_addr2, 32'h44);
    chk("m2_wc", {30'd0, word_count2}, 2);
    chk("m2_full_ready", {31'd0, in_ready2}, 0);
    tick();
    chk("m2_nowe", {31'd0, imem_we2}, 0);
    chk("m2_wc_hold", {30'd0, word_count2}, 2);
    in_valid2 = 0; finish2 = 1; tick(); finish2 = 0;
    chk("m2_drain", {31'd0, done2}, 0);
    tick();
    chk("m2_done", {31'd0, done2}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
